fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Owns the PC and drives a synchronous instruction memory that returns data one cycle after the address.
- Presents instr/pc/pc+4 to decode.
- Absorbs hazard-unit stalls with a 1-entry hold buffer, and flushes/redirects on taken branch, JAL or JALR resolved in EX.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register and a 1-entry stall hold buffer.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect targets raise a sticky flag and block fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        fetch_misalign
);

  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_buf_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        w_misalign;
  logic        w_issue;
  logic [31:0] w_target;

  assign w_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_EN
  logic r_misalign;

  // Sticky until the next redirect; an aligned target clears it on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (redirect) begin
      r_misalign <= |redirect_pc[1:0];
    end
  end

  assign w_misalign = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue        = rst_n && !redirect && !stall && !w_misalign;
  assign imem_en        = w_issue;
  assign imem_addr      = r_fetch_pc;
  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_pc          = r_id_pc;
  assign id_pc4         = r_id_pc4;
  assign fetch_misalign = w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_buf_valid   <= 1'b0;
      r_buf_instr   <= '0;
      r_buf_pc      <= '0;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= '0;
      r_id_pc4      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc  <= w_target;
        r_buf_valid <= 1'b0;
        r_id_valid  <= 1'b0;
        r_id_instr  <= NOP_INSTR;
      end else if (stall) begin
        // Issue is suppressed while stalled, so at most one return ever needs parking.
        if (r_inflight) begin
          r_buf_valid <= 1'b1;
          r_buf_instr <= imem_rdata;
          r_buf_pc    <= r_inflight_pc;
        end
      end else if (r_inflight) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rdata;
        r_id_pc    <= r_inflight_pc;
        r_id_pc4   <= r_inflight_pc + 32'd4;
      end else if (r_buf_valid) begin
        r_buf_valid <= 1'b0;
        r_id_valid  <= 1'b1;
        r_id_instr  <= r_buf_instr;
        r_id_pc     <= r_buf_pc;
        r_id_pc4    <= r_buf_pc + 32'd4;
      end else begin
        r_id_valid <= 1'b0;
        r_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: synchronous memory model plus an in-order scoreboard of expected PCs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        fetch_misalign;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pc = '0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0010_0013 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memf(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(base + 32'd4 * i);
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] e;
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = t;
    @(posedge clk);
    #1;
    if (s && !r) begin
      check("stall_imem_en", {31'd0, imem_en}, 32'd0);
      if (id_valid) check("hold_pc", id_pc, last_pc);
    end else if (id_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_pc", id_pc, 32'hDEAD_DEAD);
      end else begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e);
        check("id_instr", id_instr, memf(e));
        check("id_pc4", id_pc4, e + 32'd4);
        last_pc = e;
      end
    end
  endtask

  task automatic redirect_run(input logic [31:0] t, input int unsigned n);
    logic [31:0] a;
    a = {t[31:2], 2'b00};
    push_run(a, n - 1);
    step(1'b0, 1'b1, t);
    check("redir_bubble0", {31'd0, id_valid}, 32'd0);
    check("redir_addr", imem_addr, a);
    step(1'b0, 1'b0, '0);
    check("redir_bubble1", {31'd0, id_valid}, 32'd0);
    check("redir_addr_next", imem_addr, a + 32'd4);
    for (int unsigned i = 1; i < n; i++) step(1'b0, 1'b0, '0);
    check("redir_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc4, 32'd0);
    check("rst_en", {31'd0, imem_en}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Sequential fetch, 3-cycle stall holding 0x8, then redirect while 0x14 is in flight.
    push_run(32'h0, 5);
    step(1'b0, 1'b0, '0);
    check("first_valid_low", {31'd0, id_valid}, 32'd0);
    check("first_addr", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    check("pre_stall_pc", id_pc, 32'h8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("release_pc", id_pc, 32'hC);
    step(1'b0, 1'b0, '0);
    check("after_release_pc", id_pc, 32'h10);
    redirect_run(32'h100, 5);

    // Redirect and stall together: redirect wins.
    step(1'b1, 1'b1, 32'h40);
    check("rs_bubble", {31'd0, id_valid}, 32'd0);
    check("rs_addr", imem_addr, 32'h40);
    push_run(32'h40, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    check("rs_drained", exp_q.size(), 32'd0);

    redirect_run(32'hFFFF_FFFC, 3);

`ifdef FETCH_MISALIGN_EN
    step(1'b0, 1'b1, 32'h102);
    check("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      check("mis_en", {31'd0, imem_en}, 32'd0);
      check("mis_valid", {31'd0, id_valid}, 32'd0);
      check("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
    end
    redirect_run(32'h200, 4);
    check("mis_clear", {31'd0, fetch_misalign}, 32'd0);
`else
    redirect_run(32'h102, 4);
    check("mis_tied", {31'd0, fetch_misalign}, 32'd0);
`endif

    // Reset during a stall with a parked instruction.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_instr", id_instr, 32'h0000_0013);
    check("mrst_pc", id_pc, 32'd0);
    check("mrst_pc4", id_pc4, 32'd0);
    check("mrst_en", {31'd0, imem_en}, 32'd0);
    check("mrst_addr", imem_addr, 32'd0);
    stall = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    push_run(32'h0, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    check("final_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
